// File: rtl/bike_motion_ctrl.sv
// bike_motion_ctrl: per-player motion engine feeding the VGA controller.
// Moves the sprite STEP pixels every TICK_DIV cycles, applies the last
// captured turn request at each step, clamps at the screen edge, and
// freezes the bike when the controller reports a crash.
module bike_motion_ctrl #(
  parameter int START_X   = 20,
  parameter int START_Y   = 20,
  parameter int START_DIR = 1,
  parameter int TICK_DIV  = 250000,
  parameter int STEP      = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        game_en,
  input  logic        restart,
  input  logic        turn_left,
  input  logic        turn_right,
  input  logic        crash_in,
  output logic [31:0] bike_addr,
  output logic [31:0] bike_orient,
  output logic        alive,
  output logic        step_pulse
);

  localparam int              CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [9:0]      X_MAX    = 10'd610;
  localparam logic [8:0]      Y_MAX    = 9'd450;
  localparam logic [9:0]      STEP_X   = 10'(STEP);
  localparam logic [8:0]      STEP_Y   = 9'(STEP);
  localparam logic [9:0]      X0       = 10'(START_X);
  localparam logic [8:0]      Y0       = 9'(START_Y);
  localparam logic [1:0]      DIR0     = 2'(START_DIR);
  localparam logic [18:0]     ADDR0    = 19'(START_Y * 640 + START_X);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;
  typedef enum logic [1:0] {T_NONE, T_LEFT, T_RIGHT} turn_t;

  state_t           r_state;
  state_t           w_state_nx;
  turn_t            r_pending;
  turn_t            w_turn_req;
  logic [9:0]       r_x;
  logic [8:0]       r_y;
  logic [1:0]       r_dir;
  logic [CNT_W-1:0] r_cnt;
  logic             r_prev_l;
  logic             r_prev_r;
  logic [18:0]      r_addr;
  logic             r_step_pulse;

  logic             w_rise_l;
  logic             w_rise_r;
  logic [1:0]       w_new_dir;
  logic [9:0]       w_nx;
  logic [8:0]       w_ny;
  logic             w_oob;
  logic             w_step;
  logic [18:0]      w_addr;

  assign w_rise_l = turn_left  & ~r_prev_l;
  assign w_rise_r = turn_right & ~r_prev_r;

  // Address of the candidate position: y*640 + x as y<<9 + y<<7 + x.
  assign w_addr = ({10'd0, w_ny} << 9) + ({10'd0, w_ny} << 7) + {9'd0, w_nx};

  assign bike_addr   = {13'd0, r_addr};
  assign bike_orient = {30'd0, r_dir};
  assign alive       = (r_state != S_DEAD);
  assign step_pulse  = r_step_pulse;

  // Turn request from this cycle's edges; simultaneous left+right cancels.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_turn_req = T_NONE;
    if (w_rise_l && !w_rise_r) begin
      w_turn_req = T_LEFT;
    end else if (w_rise_r && !w_rise_l) begin
      w_turn_req = T_RIGHT;
    end
  end

  // Candidate direction and position for a step, clamped at the screen edge.
  always_comb begin
    w_new_dir = r_dir;
    if (r_pending == T_LEFT) begin
      w_new_dir = r_dir - 2'd1;
    end else if (r_pending == T_RIGHT) begin
      w_new_dir = r_dir + 2'd1;
    end
    w_nx  = r_x;
    w_ny  = r_y;
    w_oob = 1'b0;
    case (w_new_dir)
      DIR_UP: begin
        if (r_y < STEP_Y) begin
          w_ny  = 9'd0;
          w_oob = 1'b1;
        end else begin
          w_ny = r_y - STEP_Y;
        end
      end
      DIR_RIGHT: begin
        if (r_x > X_MAX - STEP_X) begin
          w_nx  = X_MAX;
          w_oob = 1'b1;
        end else begin
          w_nx = r_x + STEP_X;
        end
      end
      DIR_DOWN: begin
        if (r_y > Y_MAX - STEP_Y) begin
          w_ny  = Y_MAX;
          w_oob = 1'b1;
        end else begin
          w_ny = r_y + STEP_Y;
        end
      end
      default: begin
        if (r_x < STEP_X) begin
          w_nx  = 10'd0;
          w_oob = 1'b1;
        end else begin
          w_nx = r_x - STEP_X;
        end
      end
    endcase
  end

  // Next state and step strobe; restart beats crash, which beats the step.
  always_comb begin
    w_state_nx = r_state;
    w_step     = 1'b0;
    if (restart) begin
      w_state_nx = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (game_en) w_state_nx = S_RUN;
        S_RUN: begin
          if (crash_in) begin
            w_state_nx = S_DEAD;
          end else if (!game_en) begin
            w_state_nx = S_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            w_step = 1'b1;
            if (w_oob) w_state_nx = S_DEAD;
          end
        end
        S_DEAD:  w_state_nx = S_DEAD;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Motion datapath: tick counter, turn capture, position and address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x          <= X0;
      r_y          <= Y0;
      r_dir        <= DIR0;
      r_cnt        <= '0;
      r_pending    <= T_NONE;
      r_prev_l     <= 1'b0;
      r_prev_r     <= 1'b0;
      r_addr       <= ADDR0;
      r_step_pulse <= 1'b0;
    end else begin
      r_prev_l     <= turn_left;
      r_prev_r     <= turn_right;
      r_step_pulse <= w_step;
      r_cnt        <= (r_state == S_RUN && w_state_nx == S_RUN && !w_step)
                      ? r_cnt + CNT_W'(1) : '0;
      if (restart) begin
        r_x       <= X0;
        r_y       <= Y0;
        r_dir     <= DIR0;
        r_pending <= T_NONE;
        r_addr    <= ADDR0;
      end else if (w_step) begin
        // An edge landing on the step cycle is kept for the following step.
        r_dir     <= w_new_dir;
        r_x       <= w_nx;
        r_y       <= w_ny;
        r_addr    <= w_addr;
        r_pending <= w_turn_req;
      end else if (r_state != S_DEAD && w_turn_req != T_NONE) begin
        r_pending <= w_turn_req;
      end
    end
  end

endmodule

// File: tb/tb_bike_motion_ctrl.sv
// tb_bike_motion_ctrl: directed scenarios plus randomized play against a
// behavioural model of one bike (integer position, clamp-and-die walls).
module tb_bike_motion_ctrl;

  localparam int TICK = 4;
  localparam int STP  = 1;
  localparam int MODE_IDLE = 0;
  localparam int MODE_RUN  = 1;
  localparam int MODE_DEAD = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        game_en = 1'b0, restart = 1'b0;
  logic        turn_left = 1'b0, turn_right = 1'b0, crash_in = 1'b0;
  logic [31:0] bike_addr, bike_orient;
  logic        alive, step_pulse;

  logic        e_game_en = 1'b0;
  logic [31:0] e_bike_addr, e_bike_orient;
  logic        e_alive, e_step_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the main bike.
  int m_x, m_y, m_dir, m_cnt, m_pend, m_mode;
  bit m_prev_l, m_prev_r, m_pulse;

  bike_motion_ctrl #(.START_X(20), .START_Y(20), .START_DIR(1),
                     .TICK_DIV(TICK), .STEP(STP)) dut (
    .clock(clock), .reset(reset), .game_en(game_en), .restart(restart),
    .turn_left(turn_left), .turn_right(turn_right), .crash_in(crash_in),
    .bike_addr(bike_addr), .bike_orient(bike_orient), .alive(alive),
    .step_pulse(step_pulse));

  bike_motion_ctrl #(.START_X(609), .START_Y(20), .START_DIR(1),
                     .TICK_DIV(TICK), .STEP(2)) dut_edge (
    .clock(clock), .reset(reset), .game_en(e_game_en), .restart(1'b0),
    .turn_left(1'b0), .turn_right(1'b0), .crash_in(1'b0),
    .bike_addr(e_bike_addr), .bike_orient(e_bike_orient), .alive(e_alive),
    .step_pulse(e_step_pulse));

  initial forever #5 clock = ~clock;

  function automatic void model_reset();
    m_x = 20; m_y = 20; m_dir = 1; m_cnt = 0; m_pend = 0;
    m_mode = MODE_IDLE; m_prev_l = 0; m_prev_r = 0; m_pulse = 0;
  endfunction

  // One clock of the bike as the rules describe it, using the inputs
  // that are about to be sampled.
  function automatic void model_update();
    bit el, er;
    int req, nx, ny;
    el = turn_left && !m_prev_l;
    er = turn_right && !m_prev_r;
    req = (el && !er) ? -1 : ((er && !el) ? 1 : 0);
    m_prev_l = turn_left;
    m_prev_r = turn_right;
    m_pulse = 0;
    if (restart) begin
      m_x = 20; m_y = 20; m_dir = 1; m_cnt = 0; m_pend = 0; m_mode = MODE_IDLE;
    end else if (m_mode == MODE_IDLE) begin
      if (req != 0) m_pend = req;
      if (game_en) m_mode = MODE_RUN;
    end else if (m_mode == MODE_RUN) begin
      if (crash_in) begin
        m_mode = MODE_DEAD;
      end else if (!game_en) begin
        m_mode = MODE_IDLE;
        m_cnt = 0;
        if (req != 0) m_pend = req;
      end else if (m_cnt == TICK - 1) begin
        m_dir = (m_dir + m_pend + 4) % 4;
        m_pend = req;
        m_cnt = 0;
        nx = m_x; ny = m_y;
        case (m_dir)
          0: ny = ny - STP;
          1: nx = nx + STP;
          2: ny = ny + STP;
          default: nx = nx - STP;
        endcase
        if (nx < 0 || nx > 610 || ny < 0 || ny > 450) m_mode = MODE_DEAD;
        m_x = (nx < 0) ? 0 : ((nx > 610) ? 610 : nx);
        m_y = (ny < 0) ? 0 : ((ny > 450) ? 450 : ny);
        m_pulse = 1;
      end else begin
        m_cnt++;
        if (req != 0) m_pend = req;
      end
    end
  endfunction

  // Advance one clock; outputs are read 1 ns after the edge.
  task automatic advance();
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    #3;
    n_cmp++; if (bike_addr !== 32'd12820) begin n_bad++; $display("FAIL reset_addr: got %0d want 12820", bike_addr); end
    n_cmp++; if (bike_orient !== 32'd1) begin n_bad++; $display("FAIL reset_orient: got %0d want 1", bike_orient); end
    n_cmp++; if (alive !== 1'b1) begin n_bad++; $display("FAIL reset_alive: got %b want 1", alive); end
    n_cmp++; if (step_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse: got %b want 0", step_pulse); end
    n_cmp++; if (e_bike_addr !== 32'd13409) begin n_bad++; $display("FAIL reset_edge_addr: got %0d want 13409", e_bike_addr); end
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_straight();
    game_en = 1'b1;
    advance();  // IDLE -> RUN
    n_cmp++; if (bike_addr !== 32'd12820 || step_pulse !== 1'b0) begin n_bad++; $display("FAIL straight_entry: got addr %0d pulse %b want 12820 0", bike_addr, step_pulse); end
    for (int s = 1; s <= 2; s++) begin
      for (int c = 1; c <= TICK; c++) begin
        advance();
        n_cmp++; if (step_pulse !== (c == TICK)) begin n_bad++; $display("FAIL straight_pulse: step %0d cycle %0d got %b", s, c, step_pulse); end
      end
      n_cmp++; if (bike_addr !== 32'(12820 + s)) begin n_bad++; $display("FAIL straight_addr: got %0d want %0d", bike_addr, 12820 + s); end
    end
  endtask

  task automatic test_turns();
    game_en = 1'b0;
    restart = 1'b1; advance(); restart = 1'b0;
    turn_right = 1'b1; advance(); turn_right = 1'b0; advance();
    turn_left  = 1'b1; advance(); turn_left  = 1'b0; advance();
    turn_left  = 1'b1; advance(); turn_left  = 1'b0; advance();
    game_en = 1'b1;
    advance();
    for (int s = 1; s <= 2; s++) begin
      repeat (TICK) advance();
      n_cmp++; if (step_pulse !== 1'b1) begin n_bad++; $display("FAIL turns_pulse: got %b want 1", step_pulse); end
      n_cmp++; if (bike_orient !== 32'd0) begin n_bad++; $display("FAIL turns_orient: got %0d want 0", bike_orient); end
      n_cmp++; if (bike_addr !== 32'(12820 - 640 * s)) begin n_bad++; $display("FAIL turns_addr: got %0d want %0d", bike_addr, 12820 - 640 * s); end
    end
  endtask

  task automatic test_both();
    turn_left = 1'b1; turn_right = 1'b1; advance();
    turn_left = 1'b0; turn_right = 1'b0;
    repeat (TICK - 1) advance();
    n_cmp++; if (bike_orient !== 32'd0) begin n_bad++; $display("FAIL both_orient: got %0d want 0", bike_orient); end
    n_cmp++; if (bike_addr !== 32'd10900) begin n_bad++; $display("FAIL both_addr: got %0d want 10900", bike_addr); end
  endtask

  task automatic test_terminal_edge();
    restart = 1'b1; advance(); restart = 1'b0;
    advance();              // enter RUN
    repeat (TICK - 1) advance();
    turn_right = 1'b1; advance();   // edge lands on the step cycle
    turn_right = 1'b0;
    n_cmp++; if (bike_orient !== 32'd1 || bike_addr !== 32'd12821) begin n_bad++; $display("FAIL tc_edge_first: got orient %0d addr %0d want 1 12821", bike_orient, bike_addr); end
    repeat (TICK) advance();
    n_cmp++; if (bike_orient !== 32'd2 || bike_addr !== 32'd13461) begin n_bad++; $display("FAIL tc_edge_second: got orient %0d addr %0d want 2 13461", bike_orient, bike_addr); end
  endtask

  task automatic test_crash();
    advance(); advance();
    crash_in = 1'b1; advance(); crash_in = 1'b0;
    n_cmp++; if (alive !== 1'b0) begin n_bad++; $display("FAIL crash_alive: got %b want 0", alive); end
    for (int i = 0; i < 10; i++) begin
      advance();
      n_cmp++; if (bike_addr !== 32'd13461 || step_pulse !== 1'b0) begin n_bad++; $display("FAIL crash_frozen: got addr %0d pulse %b want 13461 0", bike_addr, step_pulse); end
    end
    restart = 1'b1; game_en = 1'b0; advance(); restart = 1'b0;
    n_cmp++; if (bike_addr !== 32'd12820 || bike_orient !== 32'd1 || alive !== 1'b1) begin n_bad++; $display("FAIL crash_restart: got addr %0d orient %0d alive %b", bike_addr, bike_orient, alive); end
    for (int i = 0; i < 10; i++) begin
      advance();
      n_cmp++; if (bike_addr !== 32'd12820 || step_pulse !== 1'b0) begin n_bad++; $display("FAIL crash_idle: got addr %0d pulse %b", bike_addr, step_pulse); end
    end
  endtask

  task automatic test_bounds();
    int n;
    n = 0;
    e_game_en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      advance();
      if (e_step_pulse) begin n = i; break; end
    end
    // One edge leaves IDLE, then TICK counted cycles to the step.
    n_cmp++; if (n !== TICK + 1) begin n_bad++; $display("FAIL bounds_step_time: got %0d want %0d", n, TICK + 1); end
    n_cmp++; if (e_bike_addr !== 32'd13410) begin n_bad++; $display("FAIL bounds_addr: got %0d want 13410", e_bike_addr); end
    n_cmp++; if (e_alive !== 1'b0) begin n_bad++; $display("FAIL bounds_alive: got %b want 0", e_alive); end
    for (int i = 0; i < 12; i++) begin
      advance();
      n_cmp++; if (e_step_pulse !== 1'b0 || e_bike_addr !== 32'd13410) begin n_bad++; $display("FAIL bounds_frozen: got pulse %b addr %0d", e_step_pulse, e_bike_addr); end
    end
    e_game_en = 1'b0;
  endtask

  task automatic test_reset_midcount();
    int n;
    n = 0;
    game_en = 1'b1;
    repeat (TICK + 3) advance();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (bike_addr !== 32'd12820 || bike_orient !== 32'd1 || alive !== 1'b1 || step_pulse !== 1'b0) begin n_bad++; $display("FAIL midreset_async: got addr %0d orient %0d alive %b pulse %b", bike_addr, bike_orient, alive, step_pulse); end
    @(posedge clock);
    #1;
    n_cmp++; if (bike_addr !== 32'd12820 || step_pulse !== 1'b0) begin n_bad++; $display("FAIL midreset_hold: got addr %0d pulse %b", bike_addr, step_pulse); end
    reset = 1'b0;
    model_reset();
    for (int i = 1; i <= 20; i++) begin
      advance();
      if (step_pulse) begin n = i; break; end
    end
    n_cmp++; if (n !== TICK + 1) begin n_bad++; $display("FAIL midreset_first_step: got %0d want %0d", n, TICK + 1); end
    n_cmp++; if (bike_addr !== 32'd12821) begin n_bad++; $display("FAIL midreset_addr: got %0d want 12821", bike_addr); end
  endtask

  task automatic test_random();
    turn_left = 1'b0; turn_right = 1'b0; crash_in = 1'b0; restart = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      game_en    = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 5) == 0) turn_left  = ~turn_left;
      if ($urandom_range(0, 5) == 0) turn_right = ~turn_right;
      crash_in   = ($urandom_range(0, 149) == 0);
      restart    = ($urandom_range(0, 199) == 0);
      advance();
      n_cmp++; if (bike_addr !== 32'(m_y * 640 + m_x)) begin n_bad++; $display("FAIL rand_addr: cycle %0d got %0d want %0d", i, bike_addr, m_y * 640 + m_x); end
      n_cmp++; if (bike_orient !== 32'(m_dir)) begin n_bad++; $display("FAIL rand_orient: cycle %0d got %0d want %0d", i, bike_orient, m_dir); end
      n_cmp++; if (alive !== (m_mode != MODE_DEAD)) begin n_bad++; $display("FAIL rand_alive: cycle %0d got %b want %b", i, alive, m_mode != MODE_DEAD); end
      n_cmp++; if (step_pulse !== m_pulse) begin n_bad++; $display("FAIL rand_pulse: cycle %0d got %b want %b", i, step_pulse, m_pulse); end
    end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_turns();
    test_both();
    test_terminal_edge();
    test_crash();
    test_bounds();
    test_reset_midcount();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
